// File: rtl/planificador_texto_pkg.sv
// Shared definitions for the LCD text path: FSM states, control codes and glyph geometry.
package pantalla_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_STROBE,
        ST_WAIT,
        ST_ADVANCE
    } estado_t;

    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_FF    = 7'h0C;
    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_TILDE = 7'h7E;

    localparam int GLYPH_W  = 6;
    localparam int GLYPH_H  = 8;
    localparam int COLS_DEF = 21;
    localparam int ROWS_DEF = 8;

    function automatic logic es_imprimible(input logic [6:0] c);
        return (c >= CH_SPACE) && (c <= CH_TILDE);
    endfunction

endpackage

// File: rtl/planificador_texto_fifo.sv
// Synchronous character FIFO; pointers carry one extra wrap bit to tell full from empty.
module fifo_caracteres #(
    parameter int DEPTH = 16,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_ok;
    logic         pop_ok;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/planificador_texto.sv
// Text scheduler: FIFO-fed FSM that drives the glyph painter one character at a time.
// Define PLANIFICADOR_CLEAR_EN to make form feed (0x0C) paint spaces over the whole screen.
module planificador_texto
    import pantalla_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int GLYPH_CYCLES = 110,
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [6:0] char_in,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       idle,
    output logic       wr,
    output logic [6:0] posx,
    output logic [5:0] posy,
    output logic [6:0] caracter
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int KW = $clog2(GLYPH_CYCLES);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
    localparam logic [KW-1:0] WAIT_LOAD = KW'(GLYPH_CYCLES - 1);

    estado_t       state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_nx;
    logic [RW-1:0] row_q, row_d, row_nx, row_inc;
    logic [KW-1:0] cnt_q, cnt_d;
    logic [6:0]    cur_char_q, cur_char_d;
    logic [6:0]    posx_q, posx_d;
    logic [5:0]    posy_q, posy_d;
    logic [6:0]    caracter_q, caracter_d;
    logic          overflow_q, overflow_d;
    logic          pop;
    logic [6:0]    fifo_dout;
`ifdef PLANIFICADOR_CLEAR_EN
    logic          clear_q, clear_d;
`endif

    function automatic logic [6:0] pos_x(input logic [CW-1:0] c);
        return 7'(32'(c) * GLYPH_W);
    endfunction

    function automatic logic [5:0] pos_y(input logic [RW-1:0] r);
        return 6'(32'(r) * GLYPH_H);
    endfunction

    fifo_caracteres #(
        .DEPTH (FIFO_DEPTH),
        .W     (7)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (char_in),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // Cursor step used by ADVANCE: wrap column, then row, with no scrolling.
    assign row_inc = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
    assign col_nx  = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
    assign row_nx  = (col_q == COL_MAX) ? row_inc : row_q;

    assign overflow_d = overflow_q | (push & full);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        cur_char_d = cur_char_q;
        posx_d     = posx_q;
        posy_d     = posy_q;
        caracter_d = caracter_q;
        pop        = 1'b0;
`ifdef PLANIFICADOR_CLEAR_EN
        clear_d    = clear_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                pop        = 1'b1;
                cur_char_d = fifo_dout;
                state_d    = ST_DECODE;
            end
            ST_DECODE: begin
                if (es_imprimible(cur_char_q)) begin
                    caracter_d = cur_char_q;
                    posx_d     = pos_x(col_q);
                    posy_d     = pos_y(row_q);
                    state_d    = ST_STROBE;
                end else if (cur_char_q == CH_LF) begin
                    col_d   = '0;
                    row_d   = row_inc;
                    state_d = ST_IDLE;
                end else if (cur_char_q == CH_CR) begin
                    col_d   = '0;
                    state_d = ST_IDLE;
                end
`ifdef PLANIFICADOR_CLEAR_EN
                else if (cur_char_q == CH_FF) begin
                    clear_d    = 1'b1;
                    col_d      = '0;
                    row_d      = '0;
                    caracter_d = CH_SPACE;
                    posx_d     = '0;
                    posy_d     = '0;
                    state_d    = ST_STROBE;
                end
`endif
                else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STROBE: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_ADVANCE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ADVANCE: begin
`ifdef PLANIFICADOR_CLEAR_EN
                if (clear_q) begin
                    // The clear walks the cursor across the screen and leaves it at home.
                    if (col_q == COL_MAX && row_q == ROW_MAX) begin
                        clear_d = 1'b0;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        col_d   = col_nx;
                        row_d   = row_nx;
                        posx_d  = pos_x(col_nx);
                        posy_d  = pos_y(row_nx);
                        state_d = ST_STROBE;
                    end
                end else begin
                    col_d   = col_nx;
                    row_d   = row_nx;
                    state_d = empty ? ST_IDLE : ST_FETCH;
                end
`else
                col_d   = col_nx;
                row_d   = row_nx;
                state_d = empty ? ST_IDLE : ST_FETCH;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            cur_char_q <= '0;
            posx_q     <= '0;
            posy_q     <= '0;
            caracter_q <= '0;
            overflow_q <= 1'b0;
`ifdef PLANIFICADOR_CLEAR_EN
            clear_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            cur_char_q <= cur_char_d;
            posx_q     <= posx_d;
            posy_q     <= posy_d;
            caracter_q <= caracter_d;
            overflow_q <= overflow_d;
`ifdef PLANIFICADOR_CLEAR_EN
            clear_q    <= clear_d;
`endif
        end
    end

    // wr decodes straight from the state register so reset removes it on the same edge.
    assign wr       = (state_q == ST_STROBE);
    assign idle     = (state_q == ST_IDLE) && empty;
    assign overflow = overflow_q;
    assign posx     = posx_q;
    assign posy     = posy_q;
    assign caracter = caracter_q;

endmodule

// File: tb/tb_planificador_texto.sv
// Self-checking bench for planificador_texto: vector table plus hand-written timing sequences.
module tb_planificador_texto;

    localparam int G = 110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [6:0] char_in = '0;
    logic       full, empty, overflow, idle, wr;
    logic [6:0] posx;
    logic [5:0] posy;
    logic [6:0] caracter;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [6:0] x;
        logic [5:0] y;
        logic [6:0] c;
    } glyph_t;

    typedef struct {
        logic [6:0] ch;
        bit         draws;
        logic [6:0] x;
        logic [5:0] y;
    } vec_t;

    glyph_t gq[$];
    vec_t   vt[$];
    int     hold_cnt = 0;
    bit     hold_bad = 1'b0;
    glyph_t hv;

    planificador_texto dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .char_in  (char_in),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .idle     (idle),
        .wr       (wr),
        .posx     (posx),
        .posy     (posy),
        .caracter (caracter)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every wr pulse and check the glyph outputs stay put for the G wait cycles after it.
    always @(negedge clk) begin
        if (rst) begin
            hold_cnt = 0;
        end else begin
            if (hold_cnt > 0) begin
                if (posx !== hv.x || posy !== hv.y || caracter !== hv.c) hold_bad = 1'b1;
                hold_cnt = hold_cnt - 1;
                if (hold_cnt == 0) begin
                    tests = tests + 1;
                    if (hold_bad) begin
                        fails = fails + 1;
                        $display("FAIL hold: outputs moved during glyph (%0d,%0d,0x%0h), now (%0d,%0d,0x%0h)",
                                 hv.x, hv.y, hv.c, posx, posy, caracter);
                    end
                end
            end
            if (wr) begin
                hv.cyc = cyc; hv.x = posx; hv.y = posy; hv.c = caracter;
                gq.push_back(hv);
                hold_cnt = G;
                hold_bad = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        push = 1'b0;
        tick();
        tick();
        gq.delete();
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [6:0] c);
        int k = 0;
        while (full && k < 1000) begin
            tick();
            k++;
        end
        if (full) chk("push_wait_not_full", 32'(full), 32'd0);
        push    = 1'b1;
        char_in = c;
        tick();
        push = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!idle && k < budget) begin
            tick();
            k++;
        end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic wait_glyphs(input int n, input int budget);
        int k = 0;
        while (gq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("glyph_count_reached", gq.size(), n);
    endtask

    function automatic void add_vec(input logic [6:0] ch, input bit draws,
                                    input logic [6:0] x, input logic [5:0] y);
        vec_t v;
        v.ch = ch; v.draws = draws; v.x = x; v.y = y;
        vt.push_back(v);
    endfunction

    initial begin
        int base;
        int bad;

        // Cursor walk from (0,0): printable glyphs, LF, CR, dropped codes, row wrap.
        add_vec(7'h41, 1, 7'd0,  6'd0);
        add_vec(7'h42, 1, 7'd6,  6'd0);
        add_vec(7'h0A, 0, 7'd0,  6'd0);
        add_vec(7'h43, 1, 7'd0,  6'd8);
        add_vec(7'h0D, 0, 7'd0,  6'd0);
        add_vec(7'h44, 1, 7'd0,  6'd8);
        add_vec(7'h7F, 0, 7'd0,  6'd0);
        add_vec(7'h01, 0, 7'd0,  6'd0);
        add_vec(7'h1F, 0, 7'd0,  6'd0);
        add_vec(7'h7E, 1, 7'd6,  6'd8);
        add_vec(7'h20, 1, 7'd12, 6'd8);
        for (int i = 0; i < 6; i++) add_vec(7'h0A, 0, 7'd0, 6'd0);
        add_vec(7'h45, 1, 7'd0,  6'd56);
        add_vec(7'h0A, 0, 7'd0,  6'd0);
        add_vec(7'h46, 1, 7'd0,  6'd0);

        do_reset();
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_posx", 32'(posx), 32'd0);
        chk("rst_posy", 32'(posy), 32'd0);
        chk("rst_caracter", 32'(caracter), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);

        // First-glyph latency: push presented from edge N, wr appears after edge N+4.
        push = 1'b1; char_in = 7'h41;
        tick();
        push = 1'b0;
        chk("lat_n1_empty", 32'(empty), 32'd0);
        chk("lat_n1_wr", 32'(wr), 32'd0);
        tick();
        chk("lat_n2_wr", 32'(wr), 32'd0);
        tick();
        chk("lat_n3_wr", 32'(wr), 32'd0);
        tick();
        chk("lat_n4_wr", 32'(wr), 32'd1);
        chk("lat_n4_posx", 32'(posx), 32'd0);
        chk("lat_n4_posy", 32'(posy), 32'd0);
        chk("lat_n4_caracter", 32'(caracter), 32'h41);
        tick();
        chk("lat_n5_wr", 32'(wr), 32'd0);
        wait_idle(300);
        push_byte(7'h42);
        wait_idle(300);
        chk("second_glyph_posx", 32'(gq[gq.size()-1].x), 32'd6);

        // Table-driven vectors.
        do_reset();
        foreach (vt[i]) begin
            base = gq.size();
            push_byte(vt[i].ch);
            wait_idle(300);
            if (vt[i].draws) begin
                chk($sformatf("vec%0d_count", i), gq.size(), base + 1);
                if (gq.size() > base) begin
                    chk($sformatf("vec%0d_posx", i), 32'(gq[base].x), 32'(vt[i].x));
                    chk($sformatf("vec%0d_posy", i), 32'(gq[base].y), 32'(vt[i].y));
                    chk($sformatf("vec%0d_char", i), 32'(gq[base].c), 32'(vt[i].ch));
                end
            end else begin
                chk($sformatf("vec%0d_no_wr", i), gq.size(), base);
            end
        end

        // 22 back-to-back glyphs: line wrap and exact wr spacing.
        do_reset();
        for (int i = 0; i < 22; i++) push_byte(7'h78);
        wait_glyphs(22, 22 * (G + 4) + 200);
        if (gq.size() >= 22) begin
            chk("x21_posx", 32'(gq[20].x), 32'd120);
            chk("x21_posy", 32'(gq[20].y), 32'd0);
            chk("x22_posx", 32'(gq[21].x), 32'd0);
            chk("x22_posy", 32'(gq[21].y), 32'd8);
            for (int i = 1; i < 22; i++)
                chk($sformatf("spacing%0d", i), gq[i].cyc - gq[i-1].cyc, G + 4);
        end
        wait_idle(300);

        // Overflow: 20 pushes while the first glyph waits; 16 accepted.
        do_reset();
        push_byte(7'h41);
        wait_glyphs(1, 50);
        for (int i = 0; i < 20; i++) begin
            push = 1'b1;
            char_in = 7'(8'h61 + i);
            tick();
        end
        push = 1'b0;
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        wait_glyphs(17, 17 * (G + 4) + 200);
        if (gq.size() >= 17)
            for (int i = 0; i < 16; i++)
                chk($sformatf("ovf_char%0d", i), 32'(gq[1+i].c), 32'(8'h61 + i));
        wait_idle(300);
        repeat (300) tick();
        chk("ovf_total_glyphs", gq.size(), 17);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during WAIT of a glyph not at the home cell.
        base = gq.size();
        push_byte(7'h51);
        push_byte(7'h52);
        wait_glyphs(base + 2, 400);
        repeat (10) tick();
        push_byte(7'h53);
        rst = 1'b1;
        tick();
        chk("rstw_wr", 32'(wr), 32'd0);
        chk("rstw_empty", 32'(empty), 32'd1);
        chk("rstw_idle", 32'(idle), 32'd1);
        chk("rstw_overflow", 32'(overflow), 32'd0);
        chk("rstw_posx", 32'(posx), 32'd0);
        gq.delete();
        rst = 1'b0;
        push_byte(7'h5A);
        wait_idle(300);
        chk("rstw_count", gq.size(), 1);
        if (gq.size() >= 1) begin
            chk("rstw_glyph_posx", 32'(gq[0].x), 32'd0);
            chk("rstw_glyph_posy", 32'(gq[0].y), 32'd0);
            chk("rstw_glyph_char", 32'(gq[0].c), 32'h5A);
        end

        // Form feed: full-screen clear when enabled, dropped otherwise.
        do_reset();
        push_byte(7'h51);
        wait_idle(300);
        push_byte(7'h0C);
`ifdef PLANIFICADOR_CLEAR_EN
        wait_glyphs(11, 12 * (G + 4));
        chk("clr_idle_low", 32'(idle), 32'd0);
        wait_glyphs(169, 169 * (G + 4) + 500);
        bad = 0;
        if (gq.size() >= 169) begin
            for (int i = 0; i < 168; i++) begin
                if (gq[1+i].x !== 7'((i % 21) * 6) || gq[1+i].y !== 6'((i / 21) * 8) ||
                    gq[1+i].c !== 7'h20) bad++;
            end
            chk("clr_last_posx", 32'(gq[168].x), 32'd120);
            chk("clr_last_posy", 32'(gq[168].y), 32'd56);
        end
        chk("clr_bad_cells", bad, 0);
        wait_idle(500);
        chk("clr_total", gq.size(), 169);
        push_byte(7'h4B);
        wait_idle(300);
        chk("ff_next_posx", 32'(gq[gq.size()-1].x), 32'd0);
`else
        wait_idle(300);
        chk("ff_no_wr", gq.size(), 1);
        push_byte(7'h4B);
        wait_idle(300);
        chk("ff_next_posx", 32'(gq[gq.size()-1].x), 32'd6);
`endif
        chk("ff_next_posy", 32'(gq[gq.size()-1].y), 32'd0);
        chk("ff_next_char", 32'(gq[gq.size()-1].c), 32'h4B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
